// File: rtl/wall_pkg.sv
// Shared screen bounds, wall extents, layout types and the per-axis bounce step
// for the wall motion controller.
package wall_pkg;

  localparam logic [9:0] X_MIN       = 10'd0;
  localparam logic [9:0] X_MAX       = 10'd639;
  localparam logic [9:0] Y_MIN       = 10'd0;
  localparam logic [9:0] Y_MAX       = 10'd479;
  localparam logic [9:0] HOR_WIDTH   = 10'd64;
  localparam logic [9:0] HOR_HEIGHT  = 10'd32;
  localparam logic [9:0] VERT_WIDTH  = 10'd32;
  localparam logic [9:0] VERT_HEIGHT = 10'd64;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    RUN  = 2'd2
  } wall_state_t;

  typedef struct packed {
    logic [9:0] x;
    logic [9:0] y;
    logic [2:0] dx;
    logic [2:0] dy;
  } wall_entry_t;

  typedef struct packed {
    logic [9:0] pos;
    logic [2:0] d;
  } axis_t;

  // Index 0 is wall 1.
  localparam logic [3:0][9:0] RESET_X = {10'd600, 10'd320, 10'd400, 10'd50};
  localparam logic [3:0][9:0] RESET_Y = {10'd400, 10'd240, 10'd200, 10'd100};

  function automatic wall_entry_t make_entry(input logic [9:0] x, input logic [9:0] y,
                                             input logic [2:0] dx, input logic [2:0] dy);
    wall_entry_t e;
    e.x  = x;
    e.y  = y;
    e.dx = dx;
    e.dy = dy;
    return e;
  endfunction

  // Walls 1 and 3 (even index) are horizontal, walls 2 and 4 are vertical.
  function automatic logic [9:0] x_hi(input logic [1:0] idx);
    logic [9:0] hi;
    if (idx[0]) hi = X_MAX - VERT_WIDTH;
    else        hi = X_MAX - HOR_WIDTH;
    return hi;
  endfunction

  function automatic logic [9:0] y_hi(input logic [1:0] idx);
    logic [9:0] hi;
    if (idx[0]) hi = Y_MAX - VERT_HEIGHT;
    else        hi = Y_MAX - HOR_HEIGHT;
    return hi;
  endfunction

  // Out-of-range candidate keeps the position and reverses the direction.
  function automatic axis_t axis_step(input logic [9:0] pos, input logic [2:0] d,
                                      input logic [9:0] lo, input logic [9:0] hi);
    logic signed [10:0] n;
    axis_t res;
    n = $signed({1'b0, pos}) + $signed({{8{d[2]}}, d});
    if ((n >= $signed({1'b0, lo})) && (n <= $signed({1'b0, hi}))) begin
      res.pos = n[9:0];
      res.d   = d;
    end else begin
      res.pos = pos;
      res.d   = 3'd0 - d;
    end
    return res;
  endfunction

endpackage

// File: rtl/wall_layout_rom.sv
// Per-level wall layout table: 8 levels x 4 walls, addressed {level, wall},
// registered output (one-cycle read latency).
module wall_layout_rom
  import wall_pkg::*;
(
  input  logic        Clk,
  input  logic [4:0]  addr,
  output wall_entry_t data
);

  wall_entry_t rom_s;

  // Layout contents; every entry lies inside its wall's legal window.
  always_comb begin
    case (addr)
      5'd0:  rom_s = make_entry(10'd100, 10'd50,  3'sd1,  3'sd1);
      5'd1:  rom_s = make_entry(10'd500, 10'd100, -3'sd1, 3'sd2);
      5'd2:  rom_s = make_entry(10'd200, 10'd400, 3'sd2,  -3'sd1);
      5'd3:  rom_s = make_entry(10'd50,  10'd300, 3'sd3,  3'sd0);
      5'd4:  rom_s = make_entry(10'd10,  10'd20,  3'sd2,  3'sd0);
      5'd5:  rom_s = make_entry(10'd605, 10'd100, 3'sd3,  -3'sd1);
      5'd6:  rom_s = make_entry(10'd1,   10'd300, -3'sd2, 3'sd3);
      5'd7:  rom_s = make_entry(10'd300, 10'd2,   3'sd0,  -3'sd3);
      5'd8:  rom_s = make_entry(10'd575, 10'd447, 3'sd3,  3'sd3);
      5'd9:  rom_s = make_entry(10'd0,   10'd0,   -3'sd3, -3'sd3);
      5'd10: rom_s = make_entry(10'd288, 10'd224, -3'sd1, 3'sd1);
      5'd11: rom_s = make_entry(10'd607, 10'd415, 3'sd1,  3'sd2);
      5'd12: rom_s = make_entry(10'd0,   10'd0,   3'sd0,  3'sd0);
      5'd13: rom_s = make_entry(10'd320, 10'd240, 3'sd2,  3'sd2);
      5'd14: rom_s = make_entry(10'd400, 10'd10,  -3'sd3, -3'sd2);
      5'd15: rom_s = make_entry(10'd100, 10'd410, 3'sd1,  -3'sd3);
      5'd16: rom_s = make_entry(10'd573, 10'd1,   3'sd2,  -3'sd2);
      5'd17: rom_s = make_entry(10'd3,   10'd412, -3'sd2, 3'sd3);
      5'd18: rom_s = make_entry(10'd50,  10'd440, 3'sd1,  3'sd3);
      5'd19: rom_s = make_entry(10'd604, 10'd50,  -3'sd3, 3'sd1);
      5'd20: rom_s = make_entry(10'd250, 10'd250, -3'sd3, 3'sd0);
      5'd21: rom_s = make_entry(10'd150, 10'd150, 3'sd0,  3'sd3);
      5'd22: rom_s = make_entry(10'd500, 10'd30,  3'sd3,  -3'sd3);
      5'd23: rom_s = make_entry(10'd20,  10'd380, -3'sd1, -3'sd1);
      5'd24: rom_s = make_entry(10'd330, 10'd100, 3'sd1,  -3'sd3);
      5'd25: rom_s = make_entry(10'd590, 10'd300, 3'sd3,  3'sd2);
      5'd26: rom_s = make_entry(10'd2,   10'd2,   -3'sd3, -3'sd3);
      5'd27: rom_s = make_entry(10'd400, 10'd200, 3'sd2,  -3'sd2);
      5'd28: rom_s = make_entry(10'd100, 10'd400, -3'sd2, 3'sd2);
      5'd29: rom_s = make_entry(10'd10,  10'd10,  3'sd1,  3'sd1);
      5'd30: rom_s = make_entry(10'd560, 10'd420, 3'sd2,  3'sd1);
      5'd31: rom_s = make_entry(10'd600, 10'd405, 3'sd3,  3'sd3);
      default: rom_s = wall_entry_t'(26'd0);
    endcase
  end

  // Synchronous read register.
  always_ff @(posedge Clk) begin
    data <= rom_s;
  end

endmodule

// File: rtl/wall_motion_ctrl.sv
// Owns the four wall positions: loads per-level layouts from the layout ROM and
// steps/bounces each wall once per synchronized frame strobe.
module wall_motion_ctrl
  import wall_pkg::*;
(
  input  logic       Clk,
  input  logic       Reset,
  input  logic       frame_clk,
  input  logic       load_req,
  input  logic [2:0] level,
  input  logic       pause,
  output logic       busy,
  output logic       load_done,
  output logic [9:0] X1,
  output logic [9:0] X2,
  output logic [9:0] X3,
  output logic [9:0] X4,
  output logic [9:0] Y1,
  output logic [9:0] Y2,
  output logic [9:0] Y3,
  output logic [9:0] Y4
);

  wall_state_t      state_r;
  logic [2:0]       level_r;
  logic [2:0]       cnt_r;
  logic             busy_r;
  logic             done_r;
  logic [2:0]       fsync_r;
  logic [3:0][9:0]  x_r;
  logic [3:0][9:0]  y_r;
  logic [3:0][2:0]  dx_r;
  logic [3:0][2:0]  dy_r;
  axis_t [3:0]      step_x_s;
  axis_t [3:0]      step_y_s;
  wall_entry_t      rom_data_s;
  logic [4:0]       rom_addr_s;
  logic [1:0]       wr_idx_s;
  logic             tick_s;

  // Data returning at count k belongs to the wall addressed at count k-1.
  assign rom_addr_s = {level_r, cnt_r[1:0]};
  assign wr_idx_s   = cnt_r[1:0] - 2'd1;
  assign tick_s     = fsync_r[1] & ~fsync_r[2];

  wall_layout_rom u_rom (
    .Clk  (Clk),
    .addr (rom_addr_s),
    .data (rom_data_s)
  );

  // Two-flop synchronizer for frame_clk plus a delayed copy for edge detect.
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      fsync_r <= 3'd0;
    end else begin
      fsync_r <= {fsync_r[1:0], frame_clk};
    end
  end

  // Candidate next position/direction of every wall on both axes.
  always_comb begin
    for (int i = 0; i < 4; i++) begin
      step_x_s[i] = axis_step(x_r[i], dx_r[i], X_MIN, x_hi(2'(i)));
      step_y_s[i] = axis_step(y_r[i], dy_r[i], Y_MIN, y_hi(2'(i)));
    end
  end

  // Load sequencing and per-frame motion.
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      state_r <= IDLE;
      level_r <= 3'd0;
      cnt_r   <= 3'd0;
      busy_r  <= 1'b0;
      done_r  <= 1'b0;
      x_r     <= RESET_X;
      y_r     <= RESET_Y;
      dx_r    <= 12'd0;
      dy_r    <= 12'd0;
    end else begin
      done_r <= 1'b0;
      case (state_r)
        IDLE: begin
          if (load_req) begin
            state_r <= LOAD;
            level_r <= level;
            cnt_r   <= 3'd0;
            busy_r  <= 1'b1;
          end else begin
            state_r <= IDLE;
          end
        end
        LOAD: begin
          cnt_r <= cnt_r + 3'd1;
          if (cnt_r != 3'd0) begin
            x_r[wr_idx_s]  <= rom_data_s.x;
            y_r[wr_idx_s]  <= rom_data_s.y;
            dx_r[wr_idx_s] <= rom_data_s.dx;
            dy_r[wr_idx_s] <= rom_data_s.dy;
          end else begin
            busy_r <= 1'b1;
          end
          if (cnt_r == 3'd4) begin
            state_r <= RUN;
            busy_r  <= 1'b0;
            done_r  <= 1'b1;
          end else begin
            state_r <= LOAD;
          end
        end
        RUN: begin
          // A load request takes priority and drops any coincident frame tick.
          if (load_req) begin
            state_r <= LOAD;
            level_r <= level;
            cnt_r   <= 3'd0;
            busy_r  <= 1'b1;
          end else if (tick_s && !pause) begin
            for (int i = 0; i < 4; i++) begin
              x_r[i]  <= step_x_s[i].pos;
              dx_r[i] <= step_x_s[i].d;
              y_r[i]  <= step_y_s[i].pos;
              dy_r[i] <= step_y_s[i].d;
            end
          end else begin
            state_r <= RUN;
          end
        end
        default: begin
          state_r <= IDLE;
          busy_r  <= 1'b0;
        end
      endcase
    end
  end

  assign busy      = busy_r;
  assign load_done = done_r;
  assign X1 = x_r[0];
  assign X2 = x_r[1];
  assign X3 = x_r[2];
  assign X4 = x_r[3];
  assign Y1 = y_r[0];
  assign Y2 = y_r[1];
  assign Y3 = y_r[2];
  assign Y4 = y_r[3];

endmodule

// File: tb/tb_wall_motion_ctrl.sv
// Self-checking bench for wall_motion_ctrl: directed load/bounce/contention cases
// plus randomized frames and loads against an arithmetic wall model.
module tb_wall_motion_ctrl;

  logic       Clk = 1'b0;
  logic       Reset = 1'b1;
  logic       frame_clk = 1'b0;
  logic       load_req = 1'b0;
  logic [2:0] level = 3'd0;
  logic       pause = 1'b0;
  logic       busy, load_done;
  logic [9:0] X1, X2, X3, X4, Y1, Y2, Y3, Y4;

  wall_motion_ctrl dut (
    .Clk(Clk), .Reset(Reset), .frame_clk(frame_clk), .load_req(load_req),
    .level(level), .pause(pause), .busy(busy), .load_done(load_done),
    .X1(X1), .X2(X2), .X3(X3), .X4(X4), .Y1(Y1), .Y2(Y2), .Y3(Y3), .Y4(Y4)
  );

  always #5 Clk = ~Clk;

  int n_checks = 0;
  int n_fail   = 0;

  // Layout table {x, y, dx, dy}, row = level*4 + wall.
  int rom_tab [32][4] = '{
    '{100, 50, 1, 1},  '{500, 100, -1, 2}, '{200, 400, 2, -1}, '{50, 300, 3, 0},
    '{10, 20, 2, 0},   '{605, 100, 3, -1}, '{1, 300, -2, 3},   '{300, 2, 0, -3},
    '{575, 447, 3, 3}, '{0, 0, -3, -3},    '{288, 224, -1, 1}, '{607, 415, 1, 2},
    '{0, 0, 0, 0},     '{320, 240, 2, 2},  '{400, 10, -3, -2}, '{100, 410, 1, -3},
    '{573, 1, 2, -2},  '{3, 412, -2, 3},   '{50, 440, 1, 3},   '{604, 50, -3, 1},
    '{250, 250, -3, 0},'{150, 150, 0, 3},  '{500, 30, 3, -3},  '{20, 380, -1, -1},
    '{330, 100, 1, -3},'{590, 300, 3, 2},  '{2, 2, -3, -3},    '{400, 200, 2, -2},
    '{100, 400, -2, 2},'{10, 10, 1, 1},    '{560, 420, 2, 1},  '{600, 405, 3, 3}
  };

  int mx[4], my[4], mdx[4], mdy[4];
  bit m_run;

  task automatic check_eq(input string tag, input int obs, input int exp);
    n_checks++;
    if (obs != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", tag, obs, exp);
    end
  endtask

  function automatic int dut_x(input int i);
    case (i)
      0: return int'(X1);
      1: return int'(X2);
      2: return int'(X3);
      default: return int'(X4);
    endcase
  endfunction

  function automatic int dut_y(input int i);
    case (i)
      0: return int'(Y1);
      1: return int'(Y2);
      2: return int'(Y3);
      default: return int'(Y4);
    endcase
  endfunction

  task automatic model_reset();
    mx = '{50, 400, 320, 600};
    my = '{100, 200, 240, 400};
    mdx = '{0, 0, 0, 0};
    mdy = '{0, 0, 0, 0};
    m_run = 1'b0;
  endtask

  task automatic model_load(input int lvl);
    for (int w = 0; w < 4; w++) begin
      mx[w]  = rom_tab[lvl*4+w][0];
      my[w]  = rom_tab[lvl*4+w][1];
      mdx[w] = rom_tab[lvl*4+w][2];
      mdy[w] = rom_tab[lvl*4+w][3];
    end
    m_run = 1'b1;
  endtask

  // One frame step: walls 1/3 are 64x32, walls 2/4 are 32x64.
  task automatic model_tick();
    int hx, hy, n;
    if (m_run) begin
      for (int w = 0; w < 4; w++) begin
        hx = (w % 2 == 0) ? 639 - 64 : 639 - 32;
        hy = (w % 2 == 0) ? 479 - 32 : 479 - 64;
        n = mx[w] + mdx[w];
        if (n < 0 || n > hx) mdx[w] = -mdx[w]; else mx[w] = n;
        n = my[w] + mdy[w];
        if (n < 0 || n > hy) mdy[w] = -mdy[w]; else my[w] = n;
      end
    end
  endtask

  task automatic check_all(input string tag);
    for (int w = 0; w < 4; w++) begin
      check_eq($sformatf("%s_X%0d", tag, w + 1), dut_x(w), mx[w]);
      check_eq($sformatf("%s_Y%0d", tag, w + 1), dut_y(w), my[w]);
    end
  endtask

  task automatic frame_pulse(input bit jitter);
    @(negedge Clk);
    if (jitter) #($urandom_range(0, 4));
    frame_clk = 1'b1;
    repeat (4) @(negedge Clk);
    frame_clk = 1'b0;
    repeat (3) @(negedge Clk);
    if (!pause) model_tick();
  endtask

  task automatic do_load(input int lvl);
    int b;
    b = lvl * 4;
    @(negedge Clk);
    level = 3'(lvl);
    load_req = 1'b1;
    @(negedge Clk);
    load_req = 1'b0;
    level = 3'($urandom_range(0, 7));
    check_eq("busy_T", int'(busy), 1);
    check_eq("done_T", int'(load_done), 0);
    @(negedge Clk);
    check_eq("X1_hold_T1", int'(X1), mx[0]);
    @(negedge Clk);
    check_eq("X1_T2", int'(X1), rom_tab[b][0]);
    check_eq("Y1_T2", int'(Y1), rom_tab[b][1]);
    check_eq("X2_hold_T2", int'(X2), mx[1]);
    repeat (2) @(negedge Clk);
    check_eq("busy_T4", int'(busy), 1);
    check_eq("done_T4", int'(load_done), 0);
    @(negedge Clk);
    check_eq("X4_T5", int'(X4), rom_tab[b+3][0]);
    check_eq("Y4_T5", int'(Y4), rom_tab[b+3][1]);
    check_eq("busy_T5", int'(busy), 0);
    check_eq("done_T5", int'(load_done), 1);
    @(negedge Clk);
    check_eq("done_T6", int'(load_done), 0);
    model_load(lvl);
    check_all("load");
  endtask

  task automatic check_reset_now(input string tag);
    model_reset();
    check_all(tag);
    check_eq({tag, "_busy"}, int'(busy), 0);
    check_eq({tag, "_done"}, int'(load_done), 0);
  endtask

  initial begin
    int dones;
    model_reset();
    repeat (3) @(negedge Clk);
    check_reset_now("rst0");
    Reset = 1'b0;

    // Frames in IDLE leave the reset layout alone.
    for (int k = 0; k < 3; k++) frame_pulse(1'b1);
    check_all("idle");

    // Level 1: steady motion plus right/left bounces.
    do_load(1);
    frame_pulse(1'b0);
    check_eq("X1_tick1", int'(X1), 12);
    check_eq("X2_tick1", int'(X2), 605);
    check_eq("X3_tick1", int'(X3), 1);
    frame_pulse(1'b1);
    check_eq("X2_tick2", int'(X2), 602);
    check_eq("X3_tick2", int'(X3), 3);
    for (int k = 0; k < 8; k++) frame_pulse(1'b1);
    check_eq("X1_ten", int'(X1), 30);
    check_eq("Y1_ten", int'(Y1), 20);
    check_all("run10");

    pause = 1'b1;
    frame_pulse(1'b1);
    pause = 1'b0;
    check_all("pause");

    // Load request in the same cycle as the frame tick: tick is dropped.
    @(negedge Clk);
    frame_clk = 1'b1;
    repeat (2) @(negedge Clk);
    level = 3'd1;
    load_req = 1'b1;
    @(negedge Clk);
    load_req = 1'b0;
    check_eq("contend_X1", int'(X1), mx[0]);
    check_eq("contend_busy", int'(busy), 1);
    frame_clk = 1'b0;
    repeat (7) @(negedge Clk);
    model_load(1);
    check_all("contend");

    // Second request during LOAD is ignored.
    dones = 0;
    @(negedge Clk);
    level = 3'd2;
    load_req = 1'b1;
    @(negedge Clk);
    load_req = 1'b0;
    repeat (2) @(negedge Clk);
    level = 3'd3;
    load_req = 1'b1;
    @(negedge Clk);
    load_req = 1'b0;
    for (int k = 0; k < 12; k++) begin
      @(negedge Clk);
      if (load_done) dones++;
    end
    check_eq("one_done", dones, 1);
    model_load(2);
    check_all("ignore2nd");

    // Randomized frames (with random pause) and loads.
    for (int it = 0; it < 40; it++) begin
      if ($urandom_range(0, 9) < 2) begin
        do_load($urandom_range(0, 7));
      end else begin
        pause = ($urandom_range(0, 3) == 0);
        frame_pulse(1'b1);
        pause = 1'b0;
        check_all("rand");
      end
    end

    // Reset while running.
    @(negedge Clk);
    Reset = 1'b1;
    #1;
    check_reset_now("rst_run");
    @(negedge Clk);
    Reset = 1'b0;

    // Reset in the middle of a load: no load_done, reset layout kept.
    @(negedge Clk);
    level = 3'd5;
    load_req = 1'b1;
    @(negedge Clk);
    load_req = 1'b0;
    repeat (3) @(negedge Clk);
    Reset = 1'b1;
    #1;
    check_reset_now("rst_load");
    @(negedge Clk);
    Reset = 1'b0;
    dones = 0;
    for (int k = 0; k < 10; k++) begin
      @(negedge Clk);
      if (load_done) dones++;
    end
    check_eq("no_done_after_rst", dones, 0);
    for (int k = 0; k < 5; k++) frame_pulse(1'b1);
    check_all("rst_idle");

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
